// File: rtl/vga_mem_arbiter_pkg.sv
// rtl/vga_mem_arbiter_pkg.sv - raster defaults, word packing constant and arbiter state type
package vga_mem_arbiter_pkg;

  localparam int DEF_H_RES   = 640;
  localparam int DEF_V_RES   = 480;
  localparam int DEF_H_TOTAL = 800;
  localparam int DEF_V_TOTAL = 525;

  localparam int PIX_PER_WORD = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DISP,
    ST_WR
  } arb_state_t;

endpackage

// File: rtl/vga_pixel_shifter.sv
// rtl/vga_pixel_shifter.sv - scanout holding register, 8-bit shifter and active-area gating
module vga_pixel_shifter
  import vga_mem_arbiter_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    disp,
  input  logic [PIX_PER_WORD-1:0] rdata,
  input  logic                    load,
  input  logic                    active,
  output logic                    pixel
);

  logic                    disp_q;
  logic [PIX_PER_WORD-1:0] hold;
  logic [PIX_PER_WORD-1:0] shift;
  logic [PIX_PER_WORD-1:0] shift_next;

  // pixel registers the post-load/post-shift MSB so column x shows at locX = x+1
  always_comb begin
    shift_next = load ? hold : {shift[PIX_PER_WORD-2:0], 1'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_q <= 1'b0;
      hold   <= '0;
      shift  <= '0;
      pixel  <= 1'b0;
    end else begin
      disp_q <= disp;
      if (disp_q) hold <= rdata;
      shift <= shift_next;
      pixel <= active & shift_next[PIX_PER_WORD-1];
    end
  end

endmodule

// File: rtl/vga_mem_arbiter.sv
// rtl/vga_mem_arbiter.sv - pixel memory arbiter: scanout fetches first, writer gets free cycles
// Define VGA_ARB_VBLANK_WRITE_EN to permit writes only during vertical blanking.
module vga_mem_arbiter
  import vga_mem_arbiter_pkg::*;
#(
  parameter int H_RES   = DEF_H_RES,
  parameter int V_RES   = DEF_V_RES,
  parameter int H_TOTAL = DEF_H_TOTAL,
  parameter int V_TOTAL = DEF_V_TOTAL,
  parameter int ADDR_W  = 16
) (
  input  logic              PIXEL_CLK,
  input  logic              RESET_N,
  input  logic [12:0]       locX,
  input  logic [12:0]       locY,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  output logic              wr_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              pixel
);

  localparam int                WPL       = H_RES / PIX_PER_WORD;
  localparam logic [12:0]       H_RES_C   = 13'(H_RES);
  localparam logic [12:0]       V_RES_C   = 13'(V_RES);
  localparam logic [12:0]       X_MID_END = 13'(H_RES - PIX_PER_WORD);
  localparam logic [12:0]       X_W0      = 13'(H_TOTAL - PIX_PER_WORD);
  localparam logic [12:0]       X_LAST    = 13'(H_TOTAL - 1);
  localparam logic [12:0]       Y_LAST    = 13'(V_TOTAL - 1);
  localparam logic [ADDR_W-1:0] WPL_A     = ADDR_W'(WPL);

  arb_state_t        state;
  logic [ADDR_W-1:0] line_base;
  logic [ADDR_W-1:0] next_base;
  logic [ADDR_W-1:0] fetch_addr;
  logic              last_line;
  logic              fetch_mid;
  logic              fetch_w0;
  logic              fetch;
  logic              wr_ok;

`ifdef VGA_ARB_VBLANK_WRITE_EN
  assign wr_ok = (locY >= V_RES_C);
`else
  assign wr_ok = 1'b1;
`endif

  always_comb begin
    last_line  = (locY == Y_LAST);
    next_base  = last_line ? '0 : line_base + WPL_A;
    fetch_mid  = (locY < V_RES_C) && (locX[2:0] == 3'd0) && (locX < X_MID_END);
    fetch_w0   = (locX == X_W0) && (last_line || ((locY + 13'd1) < V_RES_C));
    fetch      = fetch_mid || fetch_w0;
    fetch_addr = fetch_w0 ? next_base : line_base + ADDR_W'(locX[12:3]) + ADDR_W'(1);
  end

  always_ff @(posedge PIXEL_CLK or negedge RESET_N) begin
    if (!RESET_N) line_base <= '0;
    else if (locX == X_LAST) line_base <= next_base;
  end

  // A fetch point landing on the WR cycle still wins; WR never chains into another write
  always_ff @(posedge PIXEL_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= ST_IDLE;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      wr_ack    <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      wr_ack <= 1'b0;
      if (fetch) begin
        state    <= ST_DISP;
        mem_addr <= fetch_addr;
      end else if (wr_req && wr_ok && (state != ST_WR)) begin
        state     <= ST_WR;
        mem_addr  <= wr_addr;
        mem_wdata <= wr_data;
        mem_we    <= 1'b1;
        wr_ack    <= 1'b1;
      end else begin
        state <= ST_IDLE;
      end
    end
  end

  vga_pixel_shifter u_shifter (
    .clk    (PIXEL_CLK),
    .rst_n  (RESET_N),
    .disp   (state == ST_DISP),
    .rdata  (mem_rdata),
    .load   (locX[2:0] == 3'd0),
    .active ((locX < H_RES_C) && (locY < V_RES_C)),
    .pixel  (pixel)
  );

endmodule
